// File: rtl/mines_round_controller_pkg.sv
// Shared types and helpers for the Mines round controller.
package mines_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLACE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_LOST   = 3'd3,
    ST_WON    = 3'd4,
    ST_CASHED = 3'd5
  } state_t;

  // Feedback taps for x^16+x^14+x^13+x^11 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned clamp_mines(input int unsigned req,
                                              input int unsigned tiles);
    if (req < 1) return 1;
    if (req > tiles - 1) return tiles - 1;
    return req;
  endfunction

endpackage

// File: rtl/mines_round_controller_if.sv
// Front-end / display-side signal bundle of the Mines round controller.
interface mines_round_controller_if #(
  parameter int unsigned GRID_TILES = 16,
  parameter int unsigned IDX_W      = $clog2(GRID_TILES),
  parameter int unsigned SCORE_W    = 24
);
  logic                  start;
  logic [IDX_W:0]        mine_count;
  logic                  reveal_req;
  logic [IDX_W-1:0]      reveal_idx;
  logic                  cash_out;
  logic [GRID_TILES-1:0] mine_map;
  logic [GRID_TILES-1:0] revealed_map;
  logic [SCORE_W-1:0]    score;
  logic [IDX_W:0]        safe_count;
  logic [2:0]            state_o;
  logic                  busy;
  logic                  reveal_ack;
  logic                  reveal_dup;
  logic                  game_over;
  logic                  game_won;

  modport master (
    output start, mine_count, reveal_req, reveal_idx, cash_out,
    input  mine_map, revealed_map, score, safe_count, state_o,
           busy, reveal_ack, reveal_dup, game_over, game_won
  );

  modport slave (
    input  start, mine_count, reveal_req, reveal_idx, cash_out,
    output mine_map, revealed_map, score, safe_count, state_o,
           busy, reveal_ack, reveal_dup, game_over, game_won
  );
endinterface

// File: rtl/mines_round_controller_lfsr.sv
// 16-bit Fibonacci LFSR used as the mine-placement source; reseeded on rst.
module mines_lfsr16
  import mines_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else if (en) q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/mines_round_controller.sv
// Mines game-round engine: LFSR mine placement, reveal tracking, scoring and
// lose / win / cash-out resolution.
module mines_round_controller
  import mines_pkg::*;
#(
  parameter int unsigned GRID_TILES  = 16,
  parameter int unsigned IDX_W       = $clog2(GRID_TILES),
  parameter int unsigned SCORE_W     = 24,
  parameter int unsigned BASE_POINTS = 10,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic                  clk,
  input logic                  rst,
  mines_round_controller_if.slave bus
);

  localparam logic [IDX_W:0] TILES_W = (IDX_W + 1)'(GRID_TILES);

  state_t                state_q, state_d;
  logic [GRID_TILES-1:0] mine_q, mine_d, rev_q, rev_d;
  logic [SCORE_W-1:0]    score_q, score_d, points_q, points_d;
  logic [IDX_W:0]        safe_q, safe_d, placed_q, placed_d;
  logic [IDX_W:0]        mines_eff_q, mines_eff_d, mines_req;
  logic                  ack_q, ack_d, dup_q, dup_d;

  logic                  start_s, start_q, req_s, req_q;
  logic [IDX_W-1:0]      idx_s;
  logic [IDX_W:0]        mc_s;
  logic                  start_evt, rev_evt;
  logic [15:0]           lfsr_q;
  logic [IDX_W-1:0]      cand;
  logic [SCORE_W:0]      sum_w;
  logic                  unused_lfsr_hi;

  mines_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_PLACE),
    .q   (lfsr_q)
  );

  // Inputs pass one register stage; the edge is taken against a second copy,
  // which gives the two-cycle reveal-to-ack latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_s <= 1'b0;
      start_q <= 1'b0;
      req_s   <= 1'b0;
      req_q   <= 1'b0;
      idx_s   <= '0;
      mc_s    <= '0;
    end else begin
      start_s <= bus.start;
      start_q <= start_s;
      req_s   <= bus.reveal_req;
      req_q   <= req_s;
      idx_s   <= bus.reveal_idx;
      mc_s    <= bus.mine_count;
    end
  end

  assign start_evt      = start_s & ~start_q;
  assign rev_evt        = req_s & ~req_q;
  assign cand           = lfsr_q[IDX_W-1:0];
  assign unused_lfsr_hi = ^lfsr_q[15:IDX_W];
  assign sum_w          = {1'b0, score_q} + {1'b0, points_q};
  assign mines_req      = (IDX_W + 1)'(clamp_mines(32'(mc_s), GRID_TILES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mine_q      <= '0;
      rev_q       <= '0;
      score_q     <= '0;
      points_q    <= '0;
      safe_q      <= '0;
      placed_q    <= '0;
      mines_eff_q <= '0;
      ack_q       <= 1'b0;
      dup_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mine_q      <= mine_d;
      rev_q       <= rev_d;
      score_q     <= score_d;
      points_q    <= points_d;
      safe_q      <= safe_d;
      placed_q    <= placed_d;
      mines_eff_q <= mines_eff_d;
      ack_q       <= ack_d;
      dup_q       <= dup_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mine_d      = mine_q;
    rev_d       = rev_q;
    score_d     = score_q;
    points_d    = points_q;
    safe_d      = safe_q;
    placed_d    = placed_q;
    mines_eff_d = mines_eff_q;
    ack_d       = 1'b0;
    dup_d       = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOST, ST_WON, ST_CASHED: begin
        if (start_evt) begin
          state_d     = ST_PLACE;
          mine_d      = '0;
          rev_d       = '0;
          score_d     = '0;
          safe_d      = '0;
          placed_d    = '0;
          mines_eff_d = mines_req;
          points_d    = SCORE_W'(BASE_POINTS * 32'(mines_req));
        end
      end
      ST_PLACE: begin
        if (!mine_q[cand]) begin
          mine_d[cand] = 1'b1;
          placed_d     = placed_q + 1'b1;
        end
        if (placed_d == mines_eff_q) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (bus.cash_out && (safe_q != '0)) begin
          state_d = ST_CASHED;
        end else if (rev_evt) begin
          ack_d = 1'b1;
          if (rev_q[idx_s]) begin
            dup_d = 1'b1;
          end else if (mine_q[idx_s]) begin
            rev_d[idx_s] = 1'b1;
            score_d      = '0;
            state_d      = ST_LOST;
          end else begin
            rev_d[idx_s] = 1'b1;
            safe_d       = safe_q + 1'b1;
            score_d      = sum_w[SCORE_W] ? '1 : sum_w[SCORE_W-1:0];
            if (safe_d == TILES_W - mines_eff_q) state_d = ST_WON;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mine_map     = mine_q;
  assign bus.revealed_map = rev_q;
  assign bus.score        = score_q;
  assign bus.safe_count   = safe_q;
  assign bus.state_o      = state_q;
  assign bus.busy         = (state_q == ST_PLACE);
  assign bus.reveal_ack   = ack_q;
  assign bus.reveal_dup   = dup_q;
  assign bus.game_over    = (state_q == ST_LOST);
  assign bus.game_won     = (state_q == ST_WON) || (state_q == ST_CASHED);

endmodule
